// File: rtl/ctrl_pipe_if.sv
// Control-pipeline bus: decode-side inputs, per-stage hold/clear, and the
// per-stage control words plus multicycle-op status coming back out.
interface ctrl_pipe_if #(
    parameter int CW     = 16,
    parameter int STAGES = 3
);
    logic [CW-1:0]        ctrlD;
    logic                 validD;
    logic                 mcD;
    logic [STAGES-1:0]    stall;
    logic [STAGES-1:0]    flush;
    logic [STAGES*CW-1:0] ctrl_o;
    logic [STAGES-1:0]    valid_o;
    logic                 stall_req;
    logic                 mc_busy;
    logic                 mc_done;

    modport master (
        output ctrlD, validD, mcD, stall, flush,
        input  ctrl_o, valid_o, stall_req, mc_busy, mc_done
    );

    modport slave (
        input  ctrlD, validD, mcD, stall, flush,
        output ctrl_o, valid_o, stall_req, mc_busy, mc_done
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Control-word pipeline (E, M, W, ...) with per-stage stall/flush and a
// multicycle-op sequencer that holds stage 0 for MC_CYCLES+1 cycles.
//
// state | meaning
// IDLE  | no multicycle op running; requests a stall when stage 0 holds one
// BUSY  | down-counter running from MC_CYCLES-1 to 0, stall requested
// DONE  | one-cycle completion: mc_done pulses, stage-0 mc flag cleared
module ctrl_pipe #(
    parameter int CW        = 16,
    parameter int STAGES    = 3,
    parameter int MC_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    ctrl_pipe_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(MC_CYCLES - 1);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [CW-1:0]     word_q [STAGES];
    logic [CW-1:0]     word_d [STAGES];
    logic              mc_q, mc_d;
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [STAGES-1:0] in_v;
    logic [CW-1:0]     in_w [STAGES];
    logic              stall_req, mc_busy, mc_done;

    // Stage inputs: a stalled upstream stage hands down a bubble, not a copy.
    always_comb begin
        in_v    = '0;
        in_v[0] = bus.validD;
        in_w[0] = bus.ctrlD;
        for (int k = 1; k < STAGES; k++) begin
            in_v[k] = valid_q[k-1] & ~bus.stall[k-1];
            in_w[k] = word_q[k-1];
        end
    end

    // Per-stage update: flush beats stall beats load; invalid stages carry word 0.
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        for (int k = 0; k < STAGES; k++) begin
            if (bus.flush[k]) begin
                valid_d[k] = 1'b0;
                word_d[k]  = '0;
            end else if (!bus.stall[k]) begin
                valid_d[k] = in_v[k];
                word_d[k]  = in_v[k] ? in_w[k] : '0;
            end
        end
    end

    // Stage-0 mc flag; DONE clears it even while stage 0 is held so the op cannot restart.
    always_comb begin
        mc_d = mc_q;
        if (bus.flush[0]) begin
            mc_d = 1'b0;
        end else if (bus.stall[0]) begin
            if (state_q == DONE) begin
                mc_d = 1'b0;
            end
        end else begin
            mc_d = bus.validD & bus.mcD;
        end
    end

    // Multicycle sequencer next-state, timer and status outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_req = 1'b0;
        mc_busy   = 1'b0;
        mc_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_q[0] && mc_q) begin
                    stall_req = 1'b1;
                    // A flush in the same cycle empties stage 0, so there is nothing to run.
                    if (!bus.flush[0]) begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                mc_busy   = 1'b1;
                if (bus.flush[0]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                mc_done = ~bus.flush[0];
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register stage contents and sequencer state; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= '0;
            end
            mc_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= word_d[k];
            end
            mc_q    <= mc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_pack
        assign bus.ctrl_o[g*CW +: CW] = word_q[g];
    end

    assign bus.valid_o   = valid_q;
    assign bus.stall_req = stall_req;
    assign bus.mc_busy   = mc_busy;
    assign bus.mc_done   = mc_done;

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter CW, default 16: control-word width per stage.
REQ-002 SHALL have parameter STAGES, default 3: pipeline stages after decode (index 0=E, 1=M, 2=W); legal range 1..8.
REQ-003 SHALL have parameter MC_CYCLES, default 32: busy length of a multicycle op in E; legal range 2..255.
REQ-004 SHALL have one clock and a synchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have rst  in  1  synchronous, active-low (0 = reset, sampled on clk rising edge).
REQ-006 SHALL have ctrlD  in  CW  decode-stage control word.
REQ-007 SHALL have validD  in  1  ctrlD holds a real instruction.
REQ-008 SHALL have mcD  in  1  the decode instruction is multicycle (e.g. div); ignored when validD=0.
REQ-009 SHALL have stall  in  STAGES  per-stage hold; bit k holds stage k.
REQ-010 SHALL have flush  in  STAGES  per-stage clear; bit k clears stage k.
REQ-011 SHALL have ctrl_o  out  STAGES*CW  stage k word at bits [k*CW +: CW].
REQ-012 SHALL have valid_o  out  STAGES  per-stage valid.
REQ-013 SHALL have stall_req  out  1  request to hold decode and E while a multicycle op is unfinished.
REQ-014 SHALL have mc_busy  out  1  FSM in BUSY.
REQ-015 SHALL have mc_done  out  1  one-cycle pulse when a multicycle op completes.

Function
REQ-016 Stage k input SHALL be {validD, ctrlD, mcD} for k=0 and stage k-1 outputs otherwise.
REQ-017 Each stage SHALL update per cycle by priority: flush[k]=1 -> valid 0, word 0; else stall[k]=1 -> hold; else load input.
REQ-018 When stall[k-1]=1, stall[k]=0 and flush[k]=0, stage k SHALL load a bubble (valid 0, word 0), never a duplicate of stage k-1.
REQ-019 A stage with valid 0 SHALL always output word 0.
REQ-020 Stage 0 SHALL keep a private mc flag, loaded with validD & mcD, cleared by flush[0] or by the DONE state.
REQ-021 FSM states SHALL be IDLE, BUSY and DONE; reset state IDLE.
REQ-022 IDLE->BUSY SHALL occur when stage-0 valid=1 and mc flag=1, loading the down-counter with MC_CYCLES-1.
REQ-023 In BUSY the counter SHALL decrement each cycle, ignoring stall; at counter=0 BUSY->DONE.
REQ-024 DONE SHALL last exactly one cycle, assert mc_done, clear the stage-0 mc flag, and return to IDLE.
REQ-025 stall_req SHALL equal (IDLE & stage-0 valid & mc flag) | BUSY and be combinational from state; it SHALL be 0 in DONE.
REQ-026 mc_busy SHALL be 1 only in BUSY; total stall_req length for one op SHALL be MC_CYCLES+1 cycles.
REQ-027 flush[0]=1 in BUSY or DONE SHALL force IDLE next cycle, clear the counter, and suppress mc_done.
REQ-028 If stall[0]=1 holds the word through DONE, the cleared mc flag SHALL prevent a restart.
REQ-029 Simultaneous flush and stall on one stage SHALL obey flush.
REQ-030 The block SHALL NOT drive stall itself; the parent ORs stall_req into stall[0] and the decode stall.

Reset
REQ-031 With rst=0 at a rising edge, all valid_o, ctrl_o, mc flag, counter, stall_req, mc_busy and mc_done SHALL be 0 and the state IDLE after that edge.
REQ-032 Reset SHALL take priority over flush and stall and SHALL abort an in-progress multicycle op without an mc_done pulse.

Verification
REQ-033 Reset, then ctrlD=0x00A5, validD=1 for one cycle, no stall -> 0x00A5 with valid=1 in stage 0 at cycle 1, stage 1 at cycle 2, and stage 2 at cycle 3.
REQ-034 stall=3'b001 for 2 cycles with the word in stage 0 -> stage 0 holds; stage 1 shows valid 0, word 0 for 2 cycles; then the word advances.
REQ-035 mcD=1, MC_CYCLES=4, parent feeds stall_req to stall[0] -> stall_req high 5 cycles, mc_busy high 4, mc_done pulses once, and the word reaches stage 1 the cycle after DONE.
REQ-036 flush[0]=1 on the 2nd BUSY cycle -> next cycle IDLE, stall_req=0, stage-0 valid=0, and no mc_done.
REQ-037 stall[0]=1 held 3 cycles past DONE -> no second BUSY entry and a single mc_done pulse.
REQ-038 rst=0 mid-BUSY with all stages valid -> every output 0 the next cycle; normal operation resumes after rst=1.
